// File: rtl/dot_matrix_scheduler_pkg.sv
// Shared types and glyph data for the dot-matrix scheduler.
// Holds the display-mode encoding and the 8x8 digit font. In the font, row 0 is the top row.
package dot_matrix_scheduler_pkg;

   typedef enum logic [1:0] {
      MODE_PLAY    = 2'd0,
      MODE_SCORE   = 2'd1,
      MODE_WIN_ON  = 2'd2,
      MODE_WIN_OFF = 2'd3
   } mode_e;

   // Each entry is [digit][row]. Bit 7 is the leftmost column.
   localparam logic [7:0] DIGIT_FONT [10][8] = '{
      '{8'h7C, 8'hC6, 8'hCE, 8'hD6, 8'hE6, 8'hC6, 8'h7C, 8'h00},
      '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
      '{8'h7C, 8'hC6, 8'h06, 8'h1C, 8'h70, 8'hC6, 8'hFE, 8'h00},
      '{8'h7C, 8'hC6, 8'h06, 8'h3C, 8'h06, 8'hC6, 8'h7C, 8'h00},
      '{8'h1C, 8'h3C, 8'h6C, 8'hCC, 8'hFE, 8'h0C, 8'h1E, 8'h00},
      '{8'hFE, 8'hC0, 8'hFC, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00},
      '{8'h38, 8'h60, 8'hC0, 8'hFC, 8'hC6, 8'hC6, 8'h7C, 8'h00},
      '{8'hFE, 8'hC6, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
      '{8'h7C, 8'hC6, 8'hC6, 8'h7C, 8'hC6, 8'hC6, 8'h7C, 8'h00},
      '{8'h7C, 8'hC6, 8'hC6, 8'h7E, 8'h06, 8'h0C, 8'h78, 8'h00}
   };

endpackage

// File: rtl/dot_matrix_scheduler_font.sv
// Combinational glyph lookup: one row of one digit.
// Digits above 9 produce a blank row.
module dot_matrix_font
   import dot_matrix_scheduler_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic [2:0] row_i,
   output logic [7:0] bits_o
);

   always_comb begin
      bits_o = 8'h00;
      if (digit_i <= 4'd9) bits_o = DIGIT_FONT[digit_i][row_i];
   end

endmodule

// File: rtl/dot_matrix_scheduler.sv
// Row-scan timing and the display-mode state machine for two 8x8 LED panels.
// All panel outputs reload together on the row-update edge, so rows are never mixed.
module dot_matrix_scheduler
   import dot_matrix_scheduler_pkg::*;
#(
   parameter int ROW_DIV      = 2500,
   parameter int HOLD_FRAMES  = 64,
   parameter int BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] score1,
   input  logic [3:0] score2,
   input  logic       point_evt,
   input  logic       game_over,
   input  logic       winner,
   input  logic [7:0] play_row1,
   input  logic [7:0] play_row2,
   output logic [2:0] row_idx,
   output logic [7:0] dot_row,
   output logic [7:0] dot_col1,
   output logic [7:0] dot_col2,
   output logic [1:0] mode,
   output logic       frame_tick
);

   localparam int DIV_W   = (ROW_DIV > 1)      ? $clog2(ROW_DIV)      : 1;
   localparam int HOLD_W  = (HOLD_FRAMES > 1)  ? $clog2(HOLD_FRAMES)  : 1;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ROW_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   logic [DIV_W-1:0]   div_q, div_d;
   logic [2:0]         disp_row_q;
   logic [7:0]         dot_row_q, col1_q, col2_q;
   logic [7:0]         col1_d, col2_d;
   mode_e              mode_q, mode_d;
   logic               pend_q, pend_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [BLINK_W-1:0] blink_q, blink_d;
   logic               tick_q;

   logic       update, boundary, win_mode;
   logic [2:0] next_row;
   logic [7:0] font1, font2;

   assign update   = (div_q == DIV_LAST);
   assign boundary = update && (disp_row_q == 3'd7);
   assign next_row = disp_row_q + 3'd1;
   assign win_mode = (mode_q == MODE_WIN_ON) || (mode_q == MODE_WIN_OFF);
   assign div_d    = update ? '0 : div_q + 1'b1;

   dot_matrix_font u_font1 (.digit_i(score1), .row_i(next_row), .bits_o(font1));
   dot_matrix_font u_font2 (.digit_i(score2), .row_i(next_row), .bits_o(font2));

   always_comb begin
      mode_d  = mode_q;
      pend_d  = pend_q | point_evt;
      hold_d  = hold_q;
      blink_d = blink_q;
      if (boundary) begin
         if (game_over && !win_mode) begin
            mode_d  = MODE_WIN_ON;
            pend_d  = 1'b0;
            blink_d = BLINK_LAST;
         end else if (win_mode) begin
            // Points arriving during the banner stay pending until play resumes.
            if (!game_over) begin
               mode_d = MODE_PLAY;
            end else if (blink_q == '0) begin
               mode_d  = (mode_q == MODE_WIN_ON) ? MODE_WIN_OFF : MODE_WIN_ON;
               blink_d = BLINK_LAST;
            end else begin
               blink_d = blink_q - 1'b1;
            end
         end else if (pend_q || point_evt) begin
            mode_d = MODE_SCORE;
            hold_d = HOLD_LAST;
            pend_d = 1'b0;
         end else if (mode_q == MODE_SCORE) begin
            if (hold_q == '0) mode_d = MODE_PLAY;
            else              hold_d = hold_q - 1'b1;
         end
      end
   end

   always_comb begin
      col1_d = 8'h00;
      col2_d = 8'h00;
      unique case (mode_d)
         MODE_PLAY: begin
            col1_d = play_row1;
            col2_d = play_row2;
         end
         MODE_SCORE: begin
            col1_d = font1;
            col2_d = font2;
         end
         MODE_WIN_ON: begin
            col1_d = winner ? 8'h00 : font1;
            col2_d = winner ? font2 : 8'h00;
         end
         MODE_WIN_OFF: begin
            col1_d = 8'h00;
            col2_d = 8'h00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= '0;
         disp_row_q <= 3'd7;
         dot_row_q  <= 8'hFF;
         col1_q     <= 8'h00;
         col2_q     <= 8'h00;
         mode_q     <= MODE_PLAY;
         pend_q     <= 1'b0;
         hold_q     <= '0;
         blink_q    <= '0;
         tick_q     <= 1'b0;
      end else begin
         div_q   <= div_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
         blink_q <= blink_d;
         tick_q  <= boundary;
         if (update) begin
            disp_row_q <= next_row;
            dot_row_q  <= ~(8'h80 >> next_row);
            col1_q     <= col1_d;
            col2_q     <= col2_d;
         end
      end
   end

   assign row_idx    = disp_row_q + 3'd1;
   assign dot_row    = dot_row_q;
   assign dot_col1   = col1_q;
   assign dot_col2   = col2_q;
   assign mode       = mode_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_dot_matrix_scheduler.sv
// Directed bench for dot_matrix_scheduler with ROW_DIV=4, HOLD_FRAMES=2, BLINK_FRAMES=2.
module tb_dot_matrix_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] score1 = 4'd0;
   logic [3:0] score2 = 4'd0;
   logic       point_evt = 1'b0;
   logic       game_over = 1'b0;
   logic       winner = 1'b0;
   logic [7:0] play_row1 = 8'hA5;
   logic [7:0] play_row2 = 8'h3C;
   logic [2:0] row_idx;
   logic [7:0] dot_row, dot_col1, dot_col2;
   logic [1:0] mode;
   logic       frame_tick;

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_rows [8];

   dot_matrix_scheduler #(.ROW_DIV(4), .HOLD_FRAMES(2), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst(rst), .score1(score1), .score2(score2),
      .point_evt(point_evt), .game_over(game_over), .winner(winner),
      .play_row1(play_row1), .play_row2(play_row2), .row_idx(row_idx),
      .dot_row(dot_row), .dot_col1(dot_col1), .dot_col2(dot_col2),
      .mode(mode), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic wait_frame();
      int k;
      k = 0;
      do begin
         tick(1);
         k++;
      end while (frame_tick !== 1'b1 && k < 40);
      chk("frame_sync", 8'(frame_tick), 8'h01);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] r, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [1:0] m);
      chk({tag, "_row"}, dot_row, r);
      chk({tag, "_col1"}, dot_col1, c1);
      chk({tag, "_col2"}, dot_col2, c2);
      chk({tag, "_mode"}, 8'(mode), 8'(m));
   endtask

   initial begin
      exp_rows = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

      // Reset state
      tick(2);
      chk_out("rst", 8'hFF, 8'h00, 8'h00, 2'd0);
      chk("rst_tick", 8'(frame_tick), 8'h00);
      chk("rst_rowidx", 8'(row_idx), 8'h00);
      rst = 1'b0;

      // First display four edges after release
      tick(3);
      chk("pre_first_row", dot_row, 8'hFF);
      tick(1);
      chk_out("first", 8'h7F, 8'hA5, 8'h3C, 2'd0);
      chk("first_tick", 8'(frame_tick), 8'h01);
      chk("first_rowidx", 8'(row_idx), 8'h01);
      tick(1);
      chk("tick_drop", 8'(frame_tick), 8'h00);
      tick(3);
      for (int r = 1; r < 8; r++) begin
         chk("scan_row", dot_row, exp_rows[r]);
         chk("scan_tick", 8'(frame_tick), 8'h00);
         if (r < 7) tick(4);
      end
      tick(4);
      chk("period_row", dot_row, 8'h7F);
      chk("period_tick", 8'(frame_tick), 8'h01);

      // Point mid-frame: SCORE for exactly two frames
      tick(10);
      score1 = 4'd3;
      score2 = 4'd7;
      point_evt = 1'b1;
      tick(1);
      point_evt = 1'b0;
      chk("pt_latency_mode", 8'(mode), 8'h00);
      wait_frame();
      chk_out("pt_f1", 8'h7F, 8'h7C, 8'hFE, 2'd1);
      tick(4);
      chk_out("pt_f1_r1", 8'hBF, 8'hC6, 8'hC6, 2'd1);
      wait_frame();
      chk("pt_f2_mode", 8'(mode), 8'h01);
      wait_frame();
      chk_out("pt_end", 8'h7F, 8'hA5, 8'h3C, 2'd0);

      // Point in the boundary cycle, then a second point extends the hold
      tick(31);
      point_evt = 1'b1;
      tick(1);
      point_evt = 1'b0;
      chk("ext_start_tick", 8'(frame_tick), 8'h01);
      chk_out("ext_start", 8'h7F, 8'h7C, 8'hFE, 2'd1);
      tick(10);
      point_evt = 1'b1;
      score1 = 4'd12;
      tick(1);
      point_evt = 1'b0;
      wait_frame();
      chk_out("blank_r0", 8'h7F, 8'h00, 8'hFE, 2'd1);
      tick(4);
      chk_out("blank_r1", 8'hBF, 8'h00, 8'hC6, 2'd1);
      score1 = 4'd3;
      wait_frame();
      chk("ext_f3_mode", 8'(mode), 8'h01);
      wait_frame();
      chk("ext_end_mode", 8'(mode), 8'h00);

      // Game over, player 2 wins with 9
      tick(5);
      game_over = 1'b1;
      winner = 1'b1;
      score2 = 4'd9;
      tick(1);
      chk("win_latency_mode", 8'(mode), 8'h00);
      wait_frame();
      chk_out("win_on1", 8'h7F, 8'h00, 8'h7C, 2'd2);
      wait_frame();
      chk("win_on2_mode", 8'(mode), 8'h02);
      wait_frame();
      chk_out("win_off1", 8'h7F, 8'h00, 8'h00, 2'd3);
      wait_frame();
      chk_out("win_off2", 8'h7F, 8'h00, 8'h00, 2'd3);
      wait_frame();
      chk_out("win_on3", 8'h7F, 8'h00, 8'h7C, 2'd2);
      tick(6);
      game_over = 1'b0;
      tick(1);
      chk("win_hold_mode", 8'(mode), 8'h02);
      wait_frame();
      chk_out("win_exit", 8'h7F, 8'hA5, 8'h3C, 2'd0);

      // Mid-frame reset during row 3 discards a pending point
      tick(12);
      chk("pre_rst_row3", dot_row, 8'hEF);
      point_evt = 1'b1;
      tick(1);
      point_evt = 1'b0;
      rst = 1'b1;
      tick(1);
      chk_out("mid_rst", 8'hFF, 8'h00, 8'h00, 2'd0);
      chk("mid_rst_rowidx", 8'(row_idx), 8'h00);
      rst = 1'b0;
      tick(3);
      chk("mid_rst_wait", dot_row, 8'hFF);
      tick(1);
      chk_out("mid_rst_resume", 8'h7F, 8'hA5, 8'h3C, 2'd0);
      chk("mid_rst_tick", 8'(frame_tick), 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dot_matrix_scheduler.md
# dot_matrix_scheduler

- Scans the two 8x8 LED dot-matrix panels and decides, frame by frame, what they show:
  - the live playfield bitmap,
  - a held score display after each point,
  - a blinking winner banner at game over.
- Sits between the game logic (scores, events, playfield rows) and the panel pins.
- Owns row-scan timing and the display-mode state machine.

## Interface
Parameters:
- ROW_DIV, 2500: clk cycles each row is driven (must be ≥ 2).
- HOLD_FRAMES, 64: frames the score display persists after a point (≥ 1).
- BLINK_FRAMES, 32: frames per winner-banner on/off half period (≥ 1).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- score1  in  4  player 1 score, binary; values > 9 render blank.
- score2  in  4  player 2 score.
- point_evt  in  1  one-cycle pulse: a point was scored.
- game_over  in  1  level: match finished.
- winner  in  1  0 = player 1, 1 = player 2; valid while game_over = 1.
- play_row1  in  8  playfield bits for panel 1 at row row_idx.
- play_row2  in  8  playfield bits for panel 2 at row row_idx.
- row_idx  out  3  next row to be displayed; game logic presents play_row* for it.
- dot_row  out  8  active-low one-hot row select; row r drives bit 7-r low.
- dot_col1  out  8  panel 1 column data, active-high.
- dot_col2  out  8  panel 2 column data, active-high.
- mode  out  2  current mode: PLAY = 0, SCORE = 1, WIN_ON = 2, WIN_OFF = 3.
- frame_tick  out  1  one-cycle pulse at each frame boundary.

## Operation
- **Divider.** div_cnt counts 0..ROW_DIV-1 and wraps. The cycle with div_cnt = ROW_DIV-1 is an *update cycle*.
- **Row advance.** On the update-cycle edge, the displayed row advances: disp_row ← disp_row+1, wrapping 7 → 0. dot_row, dot_col1 and dot_col2 load together for the new row. row_idx always equals disp_row+1 mod 8.
- **Frame boundary.** An update cycle in which disp_row = 7 (the next row is 0). disp_row resets to 7, so the first update after reset is a boundary.
- **Event capture.** point_evt sets sticky flag pend. A point_evt in a boundary cycle is consumed by that boundary.
- **Mode decisions** happen only at boundaries, in priority order:
  - game_over = 1 and mode ∉ {WIN_ON, WIN_OFF} → WIN_ON; clear pend; blink_cnt ← BLINK_FRAMES-1.
  - In WIN_ON/WIN_OFF:
    - if game_over = 0 → PLAY;
    - else if blink_cnt = 0 → toggle WIN_ON/WIN_OFF and reload blink_cnt;
    - else decrement blink_cnt.
  - pend (including this cycle's point_evt) → SCORE; hold_cnt ← HOLD_FRAMES-1; clear pend. This also applies while already in SCORE, extending the hold.
  - In SCORE with hold_cnt = 0 → PLAY; otherwise decrement hold_cnt.
  - Otherwise the mode is unchanged.
- **Column content** for the new row r, using the mode decided at that same edge:
  - PLAY: play_row1 / play_row2, sampled in the update cycle.
  - SCORE: font(score1, r) / font(score2, r).
  - WIN_ON: the winner's panel shows font(winner's score, r); the other panel shows 0.
  - WIN_OFF: both panels 0.
- **Scores** are sampled live at every update; they are not frozen per frame.
- **Font:** digits 0–9 use the team 8x8 digit font; any other value → all rows 8'h00.

## Timing
- **Reset values** (next edge after rst = 1): div_cnt 0, disp_row 7, row_idx 0, dot_row 8'hFF, dot_col1 8'h00, dot_col2 8'h00, mode PLAY, frame_tick 0, pend 0, hold_cnt 0, blink_cnt 0.
- **First display:** dot_row = 8'h7F appears ROW_DIV cycles after rst deasserts.
- **Output coherence:** all outputs are registered. dot_row, dot_col1, dot_col2 and mode change on the same edge; they never show mixed rows.
- **frame_tick** is high for exactly the one cycle in which dot_row first equals 8'h7F of a new frame. Period = 8·ROW_DIV cycles.
- **Mode latency:** an input change takes effect at the next frame boundary, never mid-frame.
- **Mode durations:** SCORE lasts exactly HOLD_FRAMES frames with no new point. Each WIN half period lasts exactly BLINK_FRAMES frames.
- **Reset mid-operation:** rst asserted in any cycle overrides everything; pending events are discarded.

## Structure
- **Shared package:** the mode enum (2-bit encoding above) and the 10×8 digit-font constant array.
- **Sub-module dot_matrix_font:** combinational (digit[3:0], row[2:0]) → bits[7:0], returning 0 for digits > 9. Instantiate it twice, once per panel.
- **Counter widths:** $clog2 of each parameter.

## Test plan
Run with ROW_DIV = 4, HOLD_FRAMES = 2, BLINK_FRAMES = 2.
- **Reset, idle PLAY:** play_row1 = 8'hA5, play_row2 = 8'h3C held.
  - Cycle 4 after reset: dot_row 8'h7F, col1 8'hA5, col2 8'h3C, frame_tick 1.
  - dot_row then steps BF, DF, … FE every 4 cycles.
  - frame_tick repeats every 32 cycles.
- **Point:** point_evt mid-frame with score1 = 3, score2 = 7.
  - At the next boundary: mode SCORE, row-0 col1 8'h7C, col2 8'hFE.
  - Exactly 2 frames of SCORE, then PLAY.
- **Hold extension:** point_evt in a boundary cycle → SCORE starts at that edge. A second point_evt during SCORE's first frame → SCORE lasts 3 frames total.
- **Game over:** game_over = 1, winner = 1, score2 = 9 at a boundary.
  - WIN_ON: col1 0, row-0 col2 8'h7C; then WIN_OFF (both 0) for 2 frames; alternating.
  - Drop game_over → PLAY at the next boundary.
- **Blank digit:** score1 = 12 in SCORE → dot_col1 = 0 for all rows; col2 unaffected.
- **Mid-frame reset:** rst during row 3 → next edge: dot_row 8'hFF, cols 0, mode PLAY, pend cleared; 8'h7F returns 4 cycles after release.
